// File: rtl/prog_seq_pkg.sv
// Shared state type, opcode constants and opcode helper for prog_sequencer.
// SINGLE_STEP_EN adds the PAUSE state to the state type.
package prog_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StDecode,
        StFetchImm,
        StLoadImm,
        StIssue,
        StExec,
`ifdef SINGLE_STEP_EN
        StPause,
`endif
        StHalted,
        StError
    } seq_state_t;

    localparam logic [2:0]  OPC_MVI   = 3'b001;
    // All-ones; callers take the low DATA_W bits.
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    function automatic logic [2:0] opcode_of(input logic [31:0] word, input int unsigned width);
        logic [31:0] sh;
        sh = word >> (width - 3);
        return sh[2:0];
    endfunction

endpackage

// File: rtl/done_watchdog.sv
// Counts EXEC cycles without Done; expired flags the enabled cycle that reaches TIMEOUT_CYC.
// Counter saturates instead of wrapping.
module done_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != SAT)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    // The current enabled cycle is the TIMEOUT_CYC-th one.
    assign expired = enable && (cnt_q >= LAST);

endmodule

// File: rtl/prog_sequencer.sv
// Feeds ROM instructions to the processor one at a time, waiting for Done between them.
// Optional SINGLE_STEP_EN adds a step input and a PAUSE state after each Done.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned DATA_W      = 9,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned ROM_DEPTH   = 32,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] DIN,
    output logic              run,
    input  logic              Done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    // One extra pc bit so that pc == ROM_DEPTH is representable.
    localparam logic [ADDR_W:0] PC_END = (ADDR_W + 1)'(ROM_DEPTH);

    seq_state_t        state_q;
    logic [ADDR_W:0]   pc_q;
    logic [DATA_W-1:0] instr_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] din_q;
    logic              run_q;

    logic rom_is_halt;
    logic rom_is_mvi;
    logic instr_is_mvi;
    logic at_end;
    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    assign rom_is_halt  = (rom_data == HALT_WORD[DATA_W-1:0]);
    assign rom_is_mvi   = (opcode_of(32'(rom_data), DATA_W) == OPC_MVI);
    assign instr_is_mvi = (opcode_of(32'(instr_q), DATA_W) == OPC_MVI);
    assign at_end       = (pc_q == PC_END);
    assign wd_clear     = (state_q == StIssue);
    assign wd_enable    = (state_q == StExec);

    done_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            din_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (go) state_q <= StFetch;
                end
                StFetch: begin
                    state_q <= StDecode;
                end
                StDecode: begin
                    instr_q <= rom_data;
                    if (rom_is_halt) begin
                        state_q <= StHalted;
                        din_q   <= '0;
                    end else begin
                        pc_q <= pc_q + 1'b1;
                        if (rom_is_mvi) begin
                            state_q <= StFetchImm;
                        end else begin
                            state_q <= StIssue;
                            run_q   <= 1'b1;
                            din_q   <= rom_data;
                        end
                    end
                end
                StFetchImm: begin
                    // Immediate would lie past the last ROM word.
                    if (at_end) begin
                        state_q <= StError;
                        din_q   <= '0;
                    end else begin
                        state_q <= StLoadImm;
                    end
                end
                StLoadImm: begin
                    imm_q   <= rom_data;
                    pc_q    <= pc_q + 1'b1;
                    state_q <= StIssue;
                    run_q   <= 1'b1;
                    din_q   <= instr_q;
                end
                StIssue: begin
                    state_q <= StExec;
                    din_q   <= instr_is_mvi ? imm_q : instr_q;
                end
                StExec: begin
                    if (Done) begin
`ifdef SINGLE_STEP_EN
                        state_q <= StPause;
`else
                        if (at_end) begin
                            state_q <= StHalted;
                            din_q   <= '0;
                        end else begin
                            state_q <= StFetch;
                        end
`endif
                    end else if (wd_expired) begin
                        state_q <= StError;
                        din_q   <= '0;
                    end
                end
`ifdef SINGLE_STEP_EN
                StPause: begin
                    if (step) begin
                        if (at_end) begin
                            state_q <= StHalted;
                            din_q   <= '0;
                        end else begin
                            state_q <= StFetch;
                        end
                    end
                end
`endif
                StHalted, StError: begin
                    if (go) begin
                        pc_q    <= '0;
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    din_q   <= '0;
                end
            endcase
        end
    end

    assign rom_addr = pc_q[ADDR_W-1:0];
    assign pc       = pc_q[ADDR_W-1:0];
    assign DIN      = din_q;
    assign run      = run_q;
    assign busy     = !(state_q inside {StIdle, StHalted, StError});
    assign halted   = (state_q == StHalted);
    assign err      = (state_q == StError);

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomised bench for prog_sequencer: program-level reference model plus directed literal checks.
// Honours SINGLE_STEP_EN by driving a random step input.
module tb_prog_sequencer;

    localparam int DATA_W  = 9;
    localparam int ADDR_W  = 5;
    localparam int DEPTH   = 32;
    localparam int TIMEOUT = 15;

    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_ISSUE = 2;
    localparam int M_EXEC  = 3;
    localparam int M_PAUSE = 4;
    localparam int M_HALT  = 5;
    localparam int M_ERR   = 6;

    localparam int EV_ISSUE = 0;
    localparam int EV_HALT  = 1;
    localparam int EV_ERR   = 2;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic go   = 1'b0;
    logic Done = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] DIN;
    logic run;
    logic busy;
    logic halted;
    logic err;
`ifdef SINGLE_STEP_EN
    logic step = 1'b0;
    bit   step_prev = 1'b0;
`endif

    logic [DATA_W-1:0] rom [DEPTH];

    // Reference model state: what the sequencer must be doing this cycle.
    int m_mode = M_IDLE;
    int m_rem;
    int m_ev;
    int m_ev_pc;
    int m_pc = 0;
    int m_exec_n;
    logic [DATA_W-1:0] m_instr;
    logic [DATA_W-1:0] m_imm;
    bit m_mvi;
    bit go_prev;
    bit done_prev;

    int cyc = 0;
    bit chk_en = 1'b0;
    int n_tests = 0;
    int n_fail = 0;

    int rec_runs;
    int rec_go_cyc;
    int rec_first_run;
    int rec_run_cyc;
    int rec_end_cyc;
    logic [DATA_W-1:0] rec_first_din;
    logic [DATA_W-1:0] rec_exec_din;

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    prog_sequencer #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .ROM_DEPTH   (DEPTH),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
`ifdef SINGLE_STEP_EN
        .step     (step),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .DIN      (DIN),
        .run      (run),
        .Done     (Done),
        .pc       (pc),
        .busy     (busy),
        .halted   (halted),
        .err      (err)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Interpret the program word at m_pc and schedule its visible outcome.
    task automatic start_instr();
        logic [DATA_W-1:0] w;
        w = rom[m_pc];
        m_mode = M_WAIT;
        if (w == 9'h1FF) begin
            m_ev = EV_HALT;  m_rem = 2; m_ev_pc = m_pc;
        end else if (w[8:6] == 3'b001) begin
            if (m_pc + 1 == DEPTH) begin
                m_ev = EV_ERR; m_rem = 3; m_ev_pc = m_pc + 1;
            end else begin
                m_ev = EV_ISSUE; m_rem = 4; m_ev_pc = m_pc + 2;
                m_instr = w; m_imm = rom[m_pc + 1]; m_mvi = 1'b1;
            end
        end else begin
            m_ev = EV_ISSUE; m_rem = 2; m_ev_pc = m_pc + 1;
            m_instr = w; m_mvi = 1'b0;
        end
    endtask

    task automatic proceed();
        if (m_pc == DEPTH) m_mode = M_HALT;
        else start_instr();
    endtask

    task automatic model_step();
        case (m_mode)
            M_IDLE, M_HALT, M_ERR: begin
                if (go_prev) begin
                    m_pc = 0;
                    start_instr();
                end
            end
            M_WAIT: begin
                m_rem--;
                if (m_rem == 0) begin
                    m_pc = m_ev_pc;
                    if (m_ev == EV_ISSUE) m_mode = M_ISSUE;
                    else if (m_ev == EV_HALT) m_mode = M_HALT;
                    else m_mode = M_ERR;
                end
            end
            M_ISSUE: begin
                m_mode = M_EXEC;
                m_exec_n = 1;
            end
            M_EXEC: begin
                if (done_prev) begin
`ifdef SINGLE_STEP_EN
                    m_mode = M_PAUSE;
`else
                    proceed();
`endif
                end else if (m_exec_n == TIMEOUT) begin
                    m_mode = M_ERR;
                end else begin
                    m_exec_n++;
                end
            end
`ifdef SINGLE_STEP_EN
            M_PAUSE: if (step_prev) proceed();
`endif
            default: ;
        endcase
    endtask

    task automatic tick(input logic g, input logic d);
        go = g;
        Done = d;
`ifdef SINGLE_STEP_EN
        step = 1'($urandom_range(0, 1));
`endif
        @(posedge clk);
        go_prev = g;
        done_prev = d;
`ifdef SINGLE_STEP_EN
        step_prev = step;
`endif
        #1;
        cyc++;
        if (rst) model_step();
    endtask

    // delay>0: Done on that EXEC cycle; delay==0: Done with pct% chance; delay<0: never.
    task automatic run_prog(input int delay, input int pct, input int budget);
        logic d;
        logic g;
        logic last_run;
        bit fin;
        int n;
        rec_runs = 0;
        rec_first_run = -1;
        rec_first_din = 'x;
        rec_exec_din = 'x;
        rec_go_cyc = cyc;
        tick(1'b1, 1'b0);
        fin = 1'b0;
        n = 0;
        last_run = run;
        while (!fin && n < budget) begin
            if (m_mode == M_EXEC) begin
                if (delay > 0) d = (m_exec_n == delay);
                else if (delay == 0) d = ($urandom_range(0, 99) < pct);
                else d = 1'b0;
            end else begin
                d = ($urandom_range(0, 15) == 0);
            end
            g = ($urandom_range(0, 7) == 0) && busy;
            tick(g, d);
            n++;
            if (last_run && rec_runs == 1) rec_exec_din = DIN;
            if (run) begin
                if (rec_runs == 0) begin
                    rec_first_run = cyc;
                    rec_first_din = DIN;
                end
                rec_runs++;
                rec_run_cyc = cyc;
            end
            last_run = run;
            if (halted || err) begin
                fin = 1'b1;
                rec_end_cyc = cyc;
            end
        end
        check("prog_ends_in_budget", fin, 1);
    endtask

    task automatic fill_random();
        logic [DATA_W-1:0] w;
        int r;
        for (int i = 0; i < DEPTH; i++) begin
            r = $urandom_range(0, 99);
            w = 9'($urandom);
            if (r < 6) w = 9'h1FF;
            else if (r < 30) w = {3'b001, w[5:0]};
            else if (w[8:6] == 3'b001) w[8:6] = 3'b010;
            rom[i] = w;
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("run", run, m_mode == M_ISSUE);
            check("busy", busy, m_mode inside {M_WAIT, M_ISSUE, M_EXEC, M_PAUSE});
            check("halted", halted, m_mode == M_HALT);
            check("err", err, m_mode == M_ERR);
            if (m_mode != M_WAIT) begin
                check("pc", pc, m_pc & 31);
                check("rom_addr", rom_addr, m_pc & 31);
                if (m_mode == M_ISSUE) check("din_issue", DIN, m_instr);
                else if (m_mode == M_EXEC || m_mode == M_PAUSE)
                    check("din_exec", DIN, m_mvi ? m_imm : m_instr);
                else check("din_idle", DIN, 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_run", run, 0);
        check("rst_din", DIN, 0);
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);

        // ADD then HALT, Done two cycles after run.
        rom[0] = 9'o012; rom[1] = 9'h1FF;
        run_prog(2, 0, 200);
        check("t1_runs", rec_runs, 1);
        check("t1_din", rec_first_din, 9'o012);
        check("t1_latency", rec_first_run - rec_go_cyc, 3);
        check("t1_halted", halted, 1);
        check("t1_pc", pc, 1);

        // MVI with immediate, then HALT.
        rom[0] = 9'o100; rom[1] = 9'h05A; rom[2] = 9'h1FF;
        run_prog(3, 0, 200);
        check("t2_runs", rec_runs, 1);
        check("t2_din_run", rec_first_din, 9'o100);
        check("t2_din_imm", rec_exec_din, 9'h05A);
        check("t2_latency", rec_first_run - rec_go_cyc, 5);
        check("t2_halted", halted, 1);
        check("t2_pc", pc, 2);

        // No Done: watchdog error, then restart from pc 0.
        rom[0] = 9'o012; rom[1] = 9'h1FF;
        run_prog(-1, 0, 200);
        check("t3_err", err, 1);
        check("t3_timeout_cycles", rec_end_cyc - rec_run_cyc, 16);
        run_prog(1, 0, 200);
        check("t3_restart_din", rec_first_din, 9'o012);
        check("t3_restart_latency", rec_first_run - rec_go_cyc, 3);
        check("t3_restart_pc", pc, 1);

        // Full ROM without HALT.
        for (int i = 0; i < DEPTH; i++) rom[i] = 9'(10 + i);
        run_prog(1, 0, 3000);
        check("t4_runs", rec_runs, 32);
        check("t4_halted", halted, 1);
        check("t4_pc_wrapped", pc, 0);

        // MVI in the last word: error without a run for it.
        rom[31] = 9'o105;
        run_prog(1, 0, 3000);
        check("t5_runs", rec_runs, 31);
        check("t5_err", err, 1);
        check("t5_pc", pc, 0);

        // Reset asserted during EXEC.
        rom[0] = 9'o012; rom[1] = 9'o013; rom[2] = 9'h1FF;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 20 && !run; i++) tick(1'b0, 1'b0);
        check("t6_saw_run", run, 1);
        tick(1'b0, 1'b0);
        #2;
        rst = 1'b0;
        m_mode = M_IDLE;
        m_pc = 0;
        #1;
        check("t6_run", run, 0);
        check("t6_din", DIN, 0);
        check("t6_pc", pc, 0);
        check("t6_busy", busy, 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        rst = 1'b1;
        run_prog(2, 0, 200);
        check("t6_recover_runs", rec_runs, 2);
        check("t6_recover_pc", pc, 2);

        // Random programs with random Done behaviour.
        for (int k = 0; k < 30; k++) begin
            fill_random();
            run_prog(0, (k % 3 == 0) ? 10 : ((k % 3 == 1) ? 35 : 75), 4000);
            repeat ($urandom_range(0, 3)) tick(1'b0, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
